// File: rtl/pwm_duty_decoder.sv
// PWM receiver: recovers period, 7-bit duty and LED level code from a PWM
// line, using a 7-step restoring divider and a stuck-line watchdog.
module pwm_duty_decoder #(
    parameter int CNT_W   = 20,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pwm_in,
    output logic [6:0]       duty,
    output logic [CNT_W-1:0] period,
    output logic [1:0]       level,
    output logic             valid,
    output logic             stuck
);

    typedef enum logic [1:0] {
        WAIT_FIRST,
        MEASURE,
        DIVIDE
    } state_t;

    localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT);

    state_t           state_q;
    state_t           state_d;
    logic             s1;
    logic             sync;
    logic             dly;
    logic             rise;
    logic             at_to;
    logic             at_to_q;
    logic             to_hit;
    logic             capture;
    logic             finish;
    logic             to_upd;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] divisor;
    logic [CNT_W:0]   rem;
    logic [CNT_W:0]   rem_sh;
    logic [CNT_W:0]   rem_nx;
    logic [6:0]       quo;
    logic [6:0]       quo_nx;
    logic             q_bit;
    logic [2:0]       step;

    function automatic logic [1:0] lvl_of(input logic [6:0] d);
        if (d >= 7'd63) return 2'b11;
        if (d >= 7'd38) return 2'b10;
        if (d >= 7'd13) return 2'b01;
        return 2'b00;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1   <= 1'b0;
            sync <= 1'b0;
            dly  <= 1'b0;
        end else begin
            s1   <= pwm_in;
            sync <= s1;
            dly  <= sync;
        end
    end

    assign rise   = sync & ~dly;
    assign at_to  = (per_cnt == TO_V);
    // Fire only on the cycle the counter first saturates.
    assign to_hit = at_to & ~at_to_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
            at_to_q <= 1'b0;
        end else begin
            at_to_q <= at_to;
            if (rise) begin
                per_cnt <= CNT_W'(1);
                hi_cnt  <= CNT_W'(1);
            end else begin
                if (!at_to)
                    per_cnt <= per_cnt + 1'b1;
                if (sync && hi_cnt != TO_V)
                    hi_cnt <= hi_cnt + 1'b1;
            end
        end
    end

    assign rem_sh = rem << 1;
    assign q_bit  = (rem_sh >= {1'b0, divisor});
    assign rem_nx = q_bit ? rem_sh - {1'b0, divisor} : rem_sh;
    assign quo_nx = (quo << 1) | {6'd0, q_bit};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= WAIT_FIRST;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        finish  = 1'b0;
        to_upd  = 1'b0;
        unique case (state_q)
            WAIT_FIRST: begin
                if (rise) begin
                    state_d = MEASURE;
                end else if (to_hit) begin
                    to_upd = 1'b1;
                end
            end
            MEASURE: begin
                if (rise) begin
                    capture = 1'b1;
                    state_d = DIVIDE;
                end else if (to_hit) begin
                    to_upd  = 1'b1;
                    state_d = WAIT_FIRST;
                end
            end
            DIVIDE: begin
                if (step == 3'd6) begin
                    finish  = 1'b1;
                    state_d = MEASURE;
                end
            end
            default: state_d = WAIT_FIRST;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            divisor <= '0;
            rem     <= '0;
            quo     <= '0;
            step    <= '0;
        end else if (capture) begin
            divisor <= per_cnt;
            rem     <= {1'b0, hi_cnt};
            quo     <= '0;
            step    <= '0;
        end else if (state_q == DIVIDE) begin
            rem     <= rem_nx;
            quo     <= quo_nx;
            step    <= step + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty   <= '0;
            period <= '0;
            level  <= 2'b00;
            valid  <= 1'b0;
            stuck  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (finish) begin
                duty   <= quo_nx;
                level  <= lvl_of(quo_nx);
                period <= divisor;
                valid  <= 1'b1;
                stuck  <= 1'b0;
            end else if (to_upd) begin
                duty   <= sync ? 7'd127 : 7'd0;
                level  <= sync ? 2'b11 : 2'b00;
                period <= '0;
                valid  <= 1'b1;
                stuck  <= 1'b1;
            end
        end
    end

endmodule
